// File: rtl/w_sequence_tx.sv
// -----------------------------------------------------------------------------
// w_sequence_tx
//
// Transmit side of the serial w-bit stream consumed by the run detector.
// A pattern word is accepted through a valid/ready load. It is then shifted out
// MSB-first, starting at bit [nbits-1], one bit per cycle in which step_en is
// high. The pass can be repeated reps extra times. A one-cycle done pulse marks
// the end of the job.
//
// Parameters
//   WIDTH   pattern register width in bits (>= 2)
//   REP_W   width of the repeat count; total passes = reps + 1
//   LEN_W   width of the nbits field, derived as $clog2(WIDTH+1)
//
// Ports
//   clk         in   1       rising-edge clock
//   reset       in   1       asynchronous, active-low reset
//   load_valid  in   1       pattern/nbits/reps offered
//   load_ready  out  1       block can accept a load (high only in IDLE)
//   pattern     in   WIDTH   bits to send; bit [nbits-1] is sent first
//   nbits       in   LEN_W   bits per pass; 0 = empty job; >WIDTH clamps
//   reps        in   REP_W   extra passes after the first
//   step_en     in   1       advance one bit this cycle (SEND only)
//   w           out  1       serial bit; holds its value between strobes
//   w_valid     out  1       high the cycle a new bit is presented on w
//   busy        out  1       high while in SEND
//   done        out  1       one-cycle pulse when a job completes
//   z_expect    out  1       predicted detector z output
//
// Optional feature
//   RUNLEN_MON_EN  When defined, a small model of the receiver's run detector
//                  drives z_expect. z_expect is high when the bit just emitted
//                  equals the previously emitted bit of the same job.
//                  When undefined, z_expect is tied low.
// -----------------------------------------------------------------------------
module w_sequence_tx #(
    parameter  int WIDTH = 8,
    parameter  int REP_W = 4,
    localparam int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] nbits,
    input  logic [REP_W-1:0] reps,
    input  logic             step_en,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             done,
    output logic             z_expect
);

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] nbits_q, nbits_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             w_q, w_d;
    logic             w_valid_q, w_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [LEN_W-1:0] nbits_c;
    logic [WIDTH-1:0] pat_shift;
    logic             cur_bit;
    logic             handshake;
    logic             step_fire;

    // Requests longer than the register are cut down to the full width.
    assign nbits_c = (nbits > WIDTH_L) ? WIDTH_L : nbits;

    // A shift selects the current bit. idx_q is one bit wider than a
    // WIDTH-bit index needs, so a direct bit-select would not fit.
    assign pat_shift = pat_q >> idx_q;
    assign cur_bit   = pat_shift[0];

    assign load_ready = (state_q == S_IDLE);
    assign handshake  = load_valid && load_ready;
    assign step_fire  = (state_q == S_SEND) && step_en;

    // -------------------------------------------------------------------------
    // Control FSM: next state and datapath updates
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        nbits_d   = nbits_q;
        idx_d     = idx_q;
        rep_d     = rep_q;
        w_d       = w_q;
        w_valid_d = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    pat_d   = pattern;
                    nbits_d = nbits_c;
                    rep_d   = reps;
                    idx_d   = (nbits_c == '0) ? '0 : (nbits_c - ONE_L);
                    if (nbits_c == '0) begin
                        // Empty job: nothing to send, complete immediately.
                        done_d = 1'b1;
                    end else begin
                        state_d = S_SEND;
                    end
                end
            end

            S_SEND: begin
                if (step_en) begin
                    w_d       = cur_bit;
                    w_valid_d = 1'b1;
                    if (idx_q != '0) begin
                        idx_d = idx_q - ONE_L;
                    end else if (rep_q != '0) begin
                        // Start the next pass from the top bit again.
                        idx_d = nbits_q - ONE_L;
                        rep_d = rep_q - REP_ONE;
                    end else begin
                        // Final bit: done rises together with its w_valid.
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_SEND);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            nbits_q   <= '0;
            idx_q     <= '0;
            rep_q     <= '0;
            w_q       <= 1'b0;
            w_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            nbits_q   <= nbits_d;
            idx_q     <= idx_d;
            rep_q     <= rep_d;
            w_q       <= w_d;
            w_valid_q <= w_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign w       = w_q;
    assign w_valid = w_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

`ifdef RUNLEN_MON_EN
    // -------------------------------------------------------------------------
    // Run-detector model: tracks the previous bit emitted within the job
    // -------------------------------------------------------------------------
    logic last_q, last_d;
    logic have_q, have_d;   // a previous bit exists in the current job
    logic z_q, z_d;

    always_comb begin
        last_d = last_q;
        have_d = have_q;
        z_d    = z_q;
        if (handshake) begin
            have_d = 1'b0;
            z_d    = 1'b0;
        end else if (step_fire) begin
            z_d    = have_q && (cur_bit == last_q);
            last_d = cur_bit;
            have_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b0;
            have_q <= 1'b0;
            z_q    <= 1'b0;
        end else begin
            last_q <= last_d;
            have_q <= have_d;
            z_q    <= z_d;
        end
    end

    assign z_expect = z_q;
`else
    assign z_expect = 1'b0;
`endif

endmodule
